// File: rtl/seg7_pkg.sv
// Shared types and helpers for the scrolling seven-segment display.
//   char_t     : one message character, {blank, hex[3:0]}
//   SEG_BLANK  : active-low cathode pattern with every segment off
//   hex_to_seg : 4-bit hex digit -> active-low cathodes {a,b,c,d,e,f,g}
package seg7_pkg;

  typedef struct packed {
    logic       blank;
    logic [3:0] hex;
  } char_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV prescaler with enable and synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   en_i       : count enable (count holds when low)
//   clr_i      : synchronous clear to 0, wins over en_i
//   tick_o     : high for the cycle in which the count wraps DIV-1 -> 0
//   cnt_o      : current count, 0..DIV-1
module tick_gen #(
  parameter  int DIV = 4,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == CW'(DIV - 1));
  assign tick_o = en_i & at_top;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = at_top ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scroll_display.sv
// Scrolling, time-multiplexed seven-segment driver.
// A MSG_LEN-character buffer is viewed through a NUM_DIGITS-wide window whose
// start (offset) steps once per SCROLL_DIV enabled cycles. Each digit gets a
// REFRESH_DIV-cycle slot; the first BLANK_CYCLES of a slot keep all anodes off
// to avoid ghosting while cathodes change.
//   clk, reset        : clock, async active-low reset
//   enable, direction : scroll run / direction (1 = left, offset increments)
//   home              : sync pulse, offset and scroll prescaler to 0
//   wr_en/addr/data   : message buffer write port, data = {blank, hex}
//   an, seg, dp       : active-low anodes (an[0] leftmost), cathodes, dp
module seg7_scroll_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int MSG_LEN      = 16,
  parameter int REFRESH_DIV  = 100000,
  parameter int SCROLL_DIV   = 100000000,
  parameter int BLANK_CYCLES = 1000,
  localparam int AW = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  direction,
  input  logic                  home,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int SW        = $clog2(NUM_DIGITS);
  localparam int RCW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCW       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SUMW      = $clog2(MSG_LEN + NUM_DIGITS);
  // Enough conditional subtractions to fold offset+scan (< MSG_LEN+NUM_DIGITS)
  // back into 0..MSG_LEN-1, even when the message is shorter than the window.
  localparam int MOD_ITERS = NUM_DIGITS / MSG_LEN + 1;

  char_t                  mem_q [MSG_LEN];
  logic [AW-1:0]          offset_q, offset_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [6:0]             seg_q, seg_d;

  logic                   ref_tick, scr_tick;
  logic [RCW-1:0]         ref_cnt;
  logic [SCW-1:0]         scr_cnt;
  logic [SUMW-1:0]        sum;
  logic [AW-1:0]          rd_idx;
  char_t                  rd_ch;
  logic                   unused_scr;

  tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .tick_o (ref_tick),
    .cnt_o  (ref_cnt)
  );

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (enable),
    .clr_i  (home),
    .tick_o (scr_tick),
    .cnt_o  (scr_cnt)
  );

  assign unused_scr = ^scr_cnt;

  // Scan and offset next state; home beats a coincident scroll tick.
  always_comb begin
    scan_d = scan_q;
    if (ref_tick) scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;

    offset_d = offset_q;
    if (home)
      offset_d = '0;
    else if (scr_tick) begin
      if (direction) offset_d = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
      else           offset_d = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - 1'b1;
    end
  end

  // Buffer index for the digit being scanned, (offset + scan) mod MSG_LEN.
  always_comb begin
    sum = SUMW'(offset_q) + SUMW'(scan_q);
    for (int k = 0; k < MOD_ITERS; k++)
      if (sum >= SUMW'(MSG_LEN)) sum = sum - SUMW'(MSG_LEN);
    rd_idx = AW'(sum);
  end

  assign rd_ch = mem_q[rd_idx];

  always_comb begin
    an_d = '1;
    if ((BLANK_CYCLES == 0) || (ref_cnt >= RCW'(BLANK_CYCLES))) an_d[scan_q] = 1'b0;
    seg_d = rd_ch.blank ? SEG_BLANK : hex_to_seg(rd_ch.hex);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= '{blank: 1'b1, hex: 4'h0};
      offset_q <= '0;
      scan_q   <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      if (wr_en && (int'(wr_addr) < MSG_LEN)) mem_q[wr_addr] <= char_t'(wr_data);
      offset_q <= offset_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
